pipe_issue_ctrl: RTL and testbench

// - Central sequencer for the dual-lane IF/ID/EX/ME/WB pipeline. Each cycle it decides whether the ID pair

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_issue_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the dual-lane issue controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SPLIT = 2'd1,
    ST_REDIR = 2'd2
  } issue_state_t;

  localparam int NUM_LANES = 2;
  localparam int LANE0     = 0;
  localparam int LANE1     = 1;

  localparam logic [NUM_LANES-1:0] LANES_NONE = 2'b00;
  localparam logic [NUM_LANES-1:0] LANES_L0   = 2'b01;
  localparam logic [NUM_LANES-1:0] LANES_L1   = 2'b10;
  localparam logic [NUM_LANES-1:0] LANES_BOTH = 2'b11;

  // Lanes of EX that survive into ME on a redirect: lane1 is younger than
  // lane0, so a lane0 redirect kills it.
  function automatic logic [NUM_LANES-1:0] redir_keep(input logic redir_lane);
    return redir_lane ? LANES_BOTH : LANES_L0;
  endfunction

endpackage

// File: rtl/pipe_issue_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] q
);

  // Count enabled cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue sequencer for the dual-lane IF/ID/EX/ME/WB pipeline.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; pair issues together unless a hazard splits it
// ST_SPLIT | lane0 of the ID pair has issued, lane1 is pending
// ST_REDIR | refetch cycle after an EX redirect; nothing issues
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_LANES-1:0] id_valid,
  input  logic                 id_pair_dep,
  input  logic [NUM_LANES-1:0] id_load_use,
  input  logic                 ex_redirect,
  input  logic                 ex_redir_lane,
  input  logic                 me_busy,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic [NUM_LANES-1:0] ex_valid,
  output logic [NUM_LANES-1:0] me_valid,
  output logic [NUM_LANES-1:0] wb_valid,
  output logic                 split_o,
  output logic [CNT_W-1:0]     stall_cnt
);

  issue_state_t         state_q;
  issue_state_t         state_d;
  logic [NUM_LANES-1:0] ex_issue;
  logic                 lu0_hit;
  logic                 lu1_hit;
  logic                 pair_split;

  // A load-use or pair dependency only matters for lanes that actually hold work.
  assign lu0_hit    = id_load_use[LANE0] & id_valid[LANE0];
  assign lu1_hit    = id_load_use[LANE1] & id_valid[LANE1];
  assign pair_split = (id_pair_dep | lu1_hit) & (id_valid == LANES_BOTH);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: me_busy freezes the FSM, a redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    if (me_busy) begin
      state_d = state_q;
    end else if (ex_redirect) begin
      state_d = ST_REDIR;
    end else begin
      case (state_q)
        ST_RUN:   if (!lu0_hit && pair_split) state_d = ST_SPLIT;
        ST_SPLIT: if (!id_load_use[LANE1]) state_d = ST_RUN;
        ST_REDIR: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Stall/flush outputs and the issue decision for the ID pair.
  always_comb begin
    if_stall = 1'b0;
    id_stall = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    split_o  = 1'b0;
    ex_issue = LANES_NONE;
    if (!RST) begin
      split_o = (state_q == ST_SPLIT);
      if (me_busy) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
      end else if (ex_redirect) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (lu0_hit) begin
              if_stall = 1'b1;
              id_stall = 1'b1;
            end else if (pair_split) begin
              if_stall = 1'b1;
              id_stall = 1'b1;
              ex_issue = LANES_L0;
            end else if (lu1_hit) begin
              // lane1 hazard with lane0 empty: nothing to split off, just wait
              if_stall = 1'b1;
              id_stall = 1'b1;
            end else begin
              ex_issue = id_valid;
            end
          end
          ST_SPLIT: begin
            if (id_load_use[LANE1]) begin
              if_stall = 1'b1;
              id_stall = 1'b1;
            end else begin
              ex_issue = LANES_L1;
            end
          end
          default: ex_issue = LANES_NONE;
        endcase
      end
    end
  end

  // Per-lane valid pipeline EX -> ME -> WB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_valid <= LANES_NONE;
      me_valid <= LANES_NONE;
      wb_valid <= LANES_NONE;
    end else if (me_busy) begin
      wb_valid <= LANES_NONE;
    end else if (ex_redirect) begin
      ex_valid <= LANES_NONE;
      me_valid <= ex_valid & redir_keep(ex_redir_lane);
      wb_valid <= me_valid;
    end else begin
      ex_valid <= ex_issue;
      me_valid <= ex_valid;
      wb_valid <= me_valid;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK),
    .rst  (RST),
    .en   (id_stall),
    .clear(1'b0),
    .q    (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl with hand-computed expectations.
module tb_pipe_issue_ctrl;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic [1:0]       id_valid;
  logic             id_pair_dep;
  logic [1:0]       id_load_use;
  logic             ex_redirect;
  logic             ex_redir_lane;
  logic             me_busy;
  logic             if_stall;
  logic             id_stall;
  logic             flush_if;
  logic             flush_id;
  logic [1:0]       ex_valid;
  logic [1:0]       me_valid;
  logic [1:0]       wb_valid;
  logic             split_o;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .id_valid     (id_valid),
    .id_pair_dep  (id_pair_dep),
    .id_load_use  (id_load_use),
    .ex_redirect  (ex_redirect),
    .ex_redir_lane(ex_redir_lane),
    .me_busy      (me_busy),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .ex_valid     (ex_valid),
    .me_valid     (me_valid),
    .wb_valid     (wb_valid),
    .split_o      (split_o),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1;
    id_valid = 2'b00;
    id_pair_dep = 1'b0;
    id_load_use = 2'b00;
    ex_redirect = 1'b0;
    ex_redir_lane = 1'b0;
    me_busy = 1'b1;
    #2;
    check_val("rst_if_stall", if_stall, 1'b0);
    check_val("rst_id_stall", id_stall, 1'b0);
    check_val("rst_flush_if", flush_if, 1'b0);
    check_val("rst_ex", ex_valid, 2'b00);
    check_val("rst_me", me_valid, 2'b00);
    check_val("rst_wb", wb_valid, 2'b00);
    check_val("rst_split", split_o, 1'b0);
    check_val("rst_cnt", stall_cnt, 4'h0);
    me_busy = 1'b0;
    tick();
    RST = 1'b0;
    settle();

    // dual issue, no hazards
    id_valid = 2'b11;
    settle();
    check_val("dual_nostall", id_stall, 1'b0);
    tick(); check_val("dual_ex1", ex_valid, 2'b11); check_val("dual_wb1", wb_valid, 2'b00);
    tick(); check_val("dual_ex2", ex_valid, 2'b11); check_val("dual_me2", me_valid, 2'b11);
            check_val("dual_wb2", wb_valid, 2'b00);
    tick(); check_val("dual_ex3", ex_valid, 2'b11); check_val("dual_wb3", wb_valid, 2'b11);
    tick(); check_val("dual_wb4", wb_valid, 2'b11); check_val("dual_cnt", stall_cnt, 4'h0);
    id_valid = 2'b00;
    tick(); tick(); tick();
    check_val("drain_wb", wb_valid, 2'b00);

    // pair dependency splits the pair
    id_valid = 2'b11; id_pair_dep = 1'b1;
    settle();
    check_val("split_idstall0", id_stall, 1'b1);
    check_val("split_ifstall0", if_stall, 1'b1);
    check_val("split_o0", split_o, 1'b0);
    tick();
    check_val("split_ex0", ex_valid, 2'b01);
    check_val("split_o1", split_o, 1'b1);
    check_val("split_idstall1", id_stall, 1'b0);
    check_val("split_cnt", stall_cnt, 4'h1);
    tick();
    check_val("split_ex1", ex_valid, 2'b10);
    check_val("split_me1", me_valid, 2'b01);
    check_val("split_o2", split_o, 1'b0);
    id_valid = 2'b00; id_pair_dep = 1'b0;
    tick();
    check_val("split_me2", me_valid, 2'b10);
    tick(); tick();

    // lane0 load-use bubble
    id_valid = 2'b11; id_load_use = 2'b01;
    settle();
    check_val("lu_idstall", id_stall, 1'b1);
    check_val("lu_ifstall", if_stall, 1'b1);
    tick();
    check_val("lu_ex", ex_valid, 2'b00);
    check_val("lu_cnt", stall_cnt, 4'h2);
    id_load_use = 2'b00;
    settle();
    check_val("lu_release", id_stall, 1'b0);
    tick();
    check_val("lu_ex_after", ex_valid, 2'b11);

    // redirect from lane0 kills lane1
    id_valid = 2'b00; ex_redirect = 1'b1; ex_redir_lane = 1'b0;
    settle();
    check_val("redir_flush_if", flush_if, 1'b1);
    check_val("redir_flush_id", flush_id, 1'b1);
    check_val("redir_idstall", id_stall, 1'b0);
    tick();
    check_val("redir_ex", ex_valid, 2'b00);
    check_val("redir_me", me_valid, 2'b01);
    ex_redirect = 1'b0; id_valid = 2'b11;
    settle();
    check_val("redir_noflush", flush_if, 1'b0);
    tick();
    check_val("refetch_ex", ex_valid, 2'b00);
    check_val("refetch_wb", wb_valid, 2'b01);
    tick();
    check_val("run_ex", ex_valid, 2'b11);

    // redirect from lane1 keeps both lanes
    id_valid = 2'b00; ex_redirect = 1'b1; ex_redir_lane = 1'b1;
    tick();
    check_val("redir1_me", me_valid, 2'b11);
    ex_redirect = 1'b0;
    tick();
    check_val("redir1_wb", wb_valid, 2'b11);

    // redirect while in SPLIT abandons lane1
    id_valid = 2'b11; id_pair_dep = 1'b1;
    tick();
    check_val("rs_split", split_o, 1'b1);
    check_val("rs_cnt", stall_cnt, 4'h3);
    ex_redirect = 1'b1; ex_redir_lane = 1'b0;
    settle();
    check_val("rs_flush", flush_id, 1'b1);
    check_val("rs_idstall", id_stall, 1'b0);
    tick();
    check_val("rs_ex", ex_valid, 2'b00);
    check_val("rs_me", me_valid, 2'b01);
    check_val("rs_split_off", split_o, 1'b0);
    ex_redirect = 1'b0; id_valid = 2'b00; id_pair_dep = 1'b0;
    tick();
    check_val("rs_ex2", ex_valid, 2'b00);
    check_val("rs_wb", wb_valid, 2'b01);

    // me_busy with pending redirect
    id_valid = 2'b11;
    tick(); tick();
    check_val("mb_pre_me", me_valid, 2'b11);
    me_busy = 1'b1; ex_redirect = 1'b1; ex_redir_lane = 1'b0;
    settle();
    check_val("mb_ifstall", if_stall, 1'b1);
    check_val("mb_noflush", flush_if, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("mb_ex", ex_valid, 2'b11);
      check_val("mb_me", me_valid, 2'b11);
      check_val("mb_wb", wb_valid, 2'b00);
    end
    check_val("mb_cnt", stall_cnt, 4'h6);
    me_busy = 1'b0;
    settle();
    check_val("mb_flush", flush_if, 1'b1);
    check_val("mb_idstall", id_stall, 1'b0);
    tick();
    check_val("mb_ex_after", ex_valid, 2'b00);
    check_val("mb_me_after", me_valid, 2'b01);
    check_val("mb_wb_after", wb_valid, 2'b11);
    ex_redirect = 1'b0; id_valid = 2'b00;
    tick();
    check_val("mb_wb_next", wb_valid, 2'b01);

    // stall counter saturation
    id_valid = 2'b11; id_load_use = 2'b01;
    repeat (9) tick();
    check_val("sat_reach", stall_cnt, 4'hF);
    repeat (11) tick();
    check_val("sat_hold", stall_cnt, 4'hF);
    check_val("sat_stall", id_stall, 1'b1);
    id_load_use = 2'b00;

    // reset mid-SPLIT
    id_pair_dep = 1'b1;
    tick();
    check_val("rsplit_pre", split_o, 1'b1);
    check_val("rsplit_ex_pre", ex_valid, 2'b01);
    #2; RST = 1'b1; #1;
    check_val("rsplit_o", split_o, 1'b0);
    check_val("rsplit_ex", ex_valid, 2'b00);
    check_val("rsplit_me", me_valid, 2'b00);
    check_val("rsplit_wb", wb_valid, 2'b00);
    check_val("rsplit_idstall", id_stall, 1'b0);
    check_val("rsplit_cnt", stall_cnt, 4'h0);
    #2; RST = 1'b0; id_valid = 2'b00; id_pair_dep = 1'b0;
    tick();
    check_val("post_rst_split", split_o, 1'b0);
    check_val("post_rst_ex", ex_valid, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
